// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave
// AXI4-Lite responder for a 16-byte window at BASE_ADDR holding four
// DATA_WIDTH-bit read/write registers, exported in parallel on regs_out.
//
// Ports
//   s_axi_aclk, s_axi_areset   clock, asynchronous active-high reset
//   s_axi_aw*                  write address channel (slave side)
//   s_axi_w*                   write data channel, wstrb top bit ignored
//   s_axi_b*                   write response channel
//   s_axi_ar*                  read address channel
//   s_axi_r*                   read data channel
//   regs_out                   register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse                   bit k high for one cycle after register k is written
//
// Responses: OKAY=0, SLVERR=2 (in window, unaligned), DECERR=3 (outside window).
//
// Write FSM
//   state    | meaning
//   W_IDLE   | collecting AW and W, each ready drops on its own handshake
//   W_COMMIT | both captured; update bytes and raise bvalid on the next edge
//   W_RESP   | bvalid/bresp held until bready
// Read FSM
//   state    | meaning
//   R_IDLE   | arready high, waiting for AR
//   R_DATA   | rvalid/rdata/rresp held until rready

module axi_lite_reg_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]     s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [RESP_WIDTH-1:0]     s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [RESP_WIDTH-1:0]     s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [4*DATA_WIDTH-1:0]   regs_out,
    output logic [3:0]                wr_pulse
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}           rstate_t;

    function automatic logic [RESP_WIDTH-1:0] f_resp(input logic [ADDR_WIDTH-1:0] a);
        if (a[ADDR_WIDTH-1:4] != BASE_ADDR[ADDR_WIDTH-1:4])
            return RESP_WIDTH'(3);
        else if (a[1:0] != 2'b00)
            return RESP_WIDTH'(2);
        else
            return '0;
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [4];

    wstate_t               r_wstate, w_wstate_nxt;
    logic                  r_aw_done, r_w_done;
    logic                  w_aw_done_nxt, w_w_done_nxt;
    logic                  w_aw_hs, w_w_hs;
    logic                  r_awready, r_wready, r_bvalid;
    logic [RESP_WIDTH-1:0] r_bresp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic [3:0]            r_wr_pulse;
    logic [RESP_WIDTH-1:0] w_wresp;
    logic [1:0]            w_widx;

    rstate_t               r_rstate, w_rstate_nxt;
    logic                  w_ar_hs;
    logic                  r_arready, r_rvalid;
    logic [RESP_WIDTH-1:0] r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [RESP_WIDTH-1:0] w_rresp;

    // The extra strobe bit carries no byte lane.
    logic w_unused_strb;
    assign w_unused_strb = s_axi_wstrb[NB];

    assign w_wresp = f_resp(r_awaddr);
    assign w_widx  = r_awaddr[3:2];
    assign w_rresp = f_resp(s_axi_araddr);

    // ---------------- write channel ----------------
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) r_wstate <= W_IDLE;
        else              r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_aw_hs       = 1'b0;
        w_w_hs        = 1'b0;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_wstate)
            W_IDLE: begin
                w_aw_hs       = s_axi_awvalid & r_awready;
                w_w_hs        = s_axi_wvalid & r_wready;
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_done_nxt && w_w_done_nxt) w_wstate_nxt = W_COMMIT;
            end
            W_COMMIT: w_wstate_nxt = W_RESP;
            W_RESP:   if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default:  w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= '0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_pulse <= '0;
            for (int k = 0; k < 4; k++) r_regs[k] <= RESET_VAL;
        end else begin
            r_wr_pulse <= '0;
            // Done flags only live inside W_IDLE; leaving it clears them.
            r_aw_done  <= (w_wstate_nxt == W_IDLE) ? w_aw_done_nxt : 1'b0;
            r_w_done   <= (w_wstate_nxt == W_IDLE) ? w_w_done_nxt  : 1'b0;
            r_awready  <= (w_wstate_nxt == W_IDLE) && !w_aw_done_nxt;
            r_wready   <= (w_wstate_nxt == W_IDLE) && !w_w_done_nxt;
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb[NB-1:0];
            end
            if (r_wstate == W_COMMIT) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wresp;
                if (w_wresp == '0) begin
                    for (int b = 0; b < NB; b++)
                        if (r_wstrb[b]) r_regs[w_widx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                    r_wr_pulse[w_widx] <= 1'b1;
                end
            end
            if (r_wstate == W_RESP && s_axi_bready) r_bvalid <= 1'b0;
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) r_rstate <= R_IDLE;
        else              r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_ar_hs      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_ar_hs = s_axi_arvalid & r_arready;
                if (w_ar_hs) w_rstate_nxt = R_DATA;
            end
            R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Sampling r_regs here on a commit edge naturally returns the old value.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= '0;
            r_rdata   <= '0;
        end else begin
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rresp;
                r_rdata  <= (w_rresp == '0) ? r_regs[s_axi_araddr[3:2]] : '0;
            end
            if (r_rstate == R_DATA && s_axi_rready) r_rvalid <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign wr_pulse      = r_wr_pulse;

    for (genvar k = 0; k < 4; k++) begin : g_regs_out
        assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave, instance at BASE_ADDR=0x10.
module tb_axi_lite_reg_slave;

    localparam logic [31:0] RV = 32'hC0DE_0001;

    logic          clk_sys = 1'b0;
    logic          rst     = 1'b1;
    logic [7:0]    awaddr  = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata   = '0;
    logic [4:0]    wstrb   = '0;
    logic          wvalid  = 1'b0;
    logic          wready;
    logic [2:0]    bresp;
    logic          bvalid;
    logic          bready  = 1'b0;
    logic [7:0]    araddr  = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [2:0]    rresp;
    logic          rvalid;
    logic          rready  = 1'b0;
    logic [127:0]  regs_out;
    logic [3:0]    wr_pulse;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_sys = ~clk_sys;

    axi_lite_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3),
        .BASE_ADDR(8'h10), .RESET_VAL(RV)
    ) u_dut (
        .s_axi_aclk(clk_sys), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // AW and W together, bready high: bvalid one edge after the handshake edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                      input logic [2:0] exp_resp, input logic [3:0] exp_pulse);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_bvalid_early", 32'(bvalid), 32'd0);
        tick();
        chk("wr_bvalid", 32'(bvalid), 32'd1);
        chk("wr_bresp", 32'(bresp), 32'(exp_resp));
        chk("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
        tick();
        chk("wr_bvalid_clr", 32'(bvalid), 32'd0);
        chk("wr_pulse_clr", 32'(wr_pulse), 32'd0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp_d, input logic [2:0] exp_resp);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        chk("rd_rdata", rdata, exp_d);
        chk("rd_rresp", 32'(rresp), 32'(exp_resp));
        tick();
        chk("rd_rvalid_clr", 32'(rvalid), 32'd0);
        chk("rd_arready_back", 32'(arready), 32'd1);
        rready = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        for (int k = 0; k < 4; k++) chk("rst_reg", regs_out[k*32 +: 32], RV);
        rst = 1'b0;
        tick();
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_wready", 32'(wready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd1);

        // basic write/read of reg1
        wr(8'h14, 32'hDEADBEEF, 5'h0F, 3'd0, 4'b0010);
        chk("reg1_deadbeef", regs_out[63:32], 32'hDEADBEEF);
        rd(8'h14, 32'hDEADBEEF, 3'd0);

        // W three cycles ahead of AW, partial strobe
        wr(8'h10, 32'hAAAAAAAA, 5'h0F, 3'd0, 4'b0001);
        wdata = 32'h12345678; wstrb = 5'h13; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wfirst_wready", 32'(wready), 32'd0);
        chk("wfirst_awready", 32'(awready), 32'd1);
        tick(); tick();
        chk("wfirst_awready2", 32'(awready), 32'd1);
        chk("wfirst_nobvalid", 32'(bvalid), 32'd0);
        awaddr = 8'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wfirst_awready_drop", 32'(awready), 32'd0);
        tick();
        chk("wfirst_bvalid", 32'(bvalid), 32'd1);
        chk("wfirst_reg0", regs_out[31:0], 32'hAAAA5678);
        chk("wfirst_pulse", 32'(wr_pulse), 32'd1);
        tick();
        chk("wfirst_bvalid_clr", 32'(bvalid), 32'd0);

        // write response backpressure
        awaddr = 8'h1C; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 5'h0F; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", 32'(bvalid), 32'd1);
            chk("bp_bresp", 32'(bresp), 32'd0);
            chk("bp_awready", 32'(awready), 32'd0);
            chk("bp_wready", 32'(wready), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        chk("bp_bvalid_clr", 32'(bvalid), 32'd0);
        chk("bp_awready_back", 32'(awready), 32'd1);
        chk("bp_reg3", regs_out[127:96], 32'h0BADF00D);

        // read data backpressure
        araddr = 8'h1C; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rbp_rvalid", 32'(rvalid), 32'd1);
            chk("rbp_rdata", rdata, 32'h0BADF00D);
            chk("rbp_arready", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        chk("rbp_rvalid_clr", 32'(rvalid), 32'd0);
        rready = 1'b0;

        // errors and decode
        wr(8'h04, 32'hFFFFFFFF, 5'h0F, 3'd3, 4'b0000);
        chk("decerr_reg0", regs_out[31:0], 32'hAAAA5678);
        chk("decerr_reg1", regs_out[63:32], 32'hDEADBEEF);
        wr(8'h15, 32'hFFFFFFFF, 5'h0F, 3'd2, 4'b0000);
        chk("slverr_reg1", regs_out[63:32], 32'hDEADBEEF);
        rd(8'h16, 32'h0, 3'd2);
        rd(8'h04, 32'h0, 3'd3);
        rd(8'h1C, 32'h0BADF00D, 3'd0);

        // zero strobe: OKAY, pulse, no data change
        wr(8'h18, 32'hFFFFFFFF, 5'h00, 3'd0, 4'b0100);
        chk("zstrb_reg2", regs_out[95:64], RV);

        // read/write collision on reg2
        wr(8'h18, 32'h11, 5'h0F, 3'd0, 4'b0100);
        awaddr = 8'h18; awvalid = 1'b1; wdata = 32'h22; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 8'h18; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("coll_rvalid", 32'(rvalid), 32'd1);
        chk("coll_rdata_old", rdata, 32'h11);
        chk("coll_bvalid", 32'(bvalid), 32'd1);
        chk("coll_reg2_new", regs_out[95:64], 32'h22);
        tick();
        rready = 1'b0;
        rd(8'h18, 32'h22, 3'd0);

        // reset while in W_RESP
        bready = 1'b0;
        awaddr = 8'h14; awvalid = 1'b1; wdata = 32'h5555AAAA; wstrb = 5'h0F; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("mid_bvalid", 32'(bvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        chk("mid_rst_awready", 32'(awready), 32'd0);
        chk("mid_rst_arready", 32'(arready), 32'd0);
        for (int k = 0; k < 4; k++) chk("mid_rst_reg", regs_out[k*32 +: 32], RV);
        tick();
        chk("mid_rst_wready", 32'(wready), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_awready", 32'(awready), 32'd1);
        chk("post_wready", 32'(wready), 32'd1);
        chk("post_arready", 32'(arready), 32'd1);
        chk("post_bvalid", 32'(bvalid), 32'd0);
        rd(8'h14, RV, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
